// File: rtl/sumatoria_ctrl_if.sv
// Host/counter-facing bundle for the Sumatoria control and accumulate stage.
//
// Handshake: the host raises start for at least one cycle while busy=0 and
// done=0 (the block is idle); that cycle's target is captured. busy then stays
// high until the run ends, and done pulses for exactly one cycle when sum and
// overflow are final. result_valid stays high from done until the next
// accepted start. abort, sampled while busy, ends the run early with no done.
// start while busy or during done is ignored (no queueing).
interface sumatoria_ctrl_if #(
  parameter int COUNT_W = 11,
  parameter int SUM_W   = 22
);
  logic               start;
  logic               abort;
  logic [COUNT_W-1:0] target;
  logic [COUNT_W-1:0] count_in;
  logic               cnt_enable;
  logic               cnt_hard_reset;
  logic               busy;
  logic               done;
  logic               result_valid;
  logic [SUM_W-1:0]   sum;
  logic               overflow;
  logic [1:0]         dbg_state;

  modport slave (
    input  start, abort, target, count_in,
    output cnt_enable, cnt_hard_reset, busy, done, result_valid, sum,
           overflow, dbg_state
  );

  modport master (
    output start, abort, target, count_in,
    input  cnt_enable, cnt_hard_reset, busy, done, result_valid, sum,
           overflow, dbg_state
  );
endinterface

// File: rtl/sumatoria_ctrl.sv
// Control and accumulate stage for the Sumatoria datapath: clears and enables
// the external up-counter, adds every count it presents until the count equals
// the captured target, and reports S = 0+1+...+N with a sticky overflow flag.
module sumatoria_ctrl #(
  parameter int COUNT_W = 11,
  parameter int SUM_W   = 22
) (
  input logic             clk,
  input logic             rst,
  sumatoria_ctrl_if.slave ctrl
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // One spare bit above the wider operand keeps the carry out of the
  // SUM_W-bit accumulator visible even when count_in is wider than sum.
  localparam int AW = ((SUM_W > COUNT_W) ? SUM_W : COUNT_W) + 1;

  logic [1:0]         state_q, state_d;
  logic [COUNT_W-1:0] target_q, target_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               overflow_q, overflow_d;
  logic               result_valid_q, result_valid_d;
  logic               cnt_enable_q, cnt_enable_d;
  logic               cnt_hard_reset_q, cnt_hard_reset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [AW-1:0]      acc_wide;
  logic               acc_carry;

  // Zero-extended add of the current count; any bit above SUM_W is a carry out
  always_comb begin
    acc_wide  = AW'(sum_q) + AW'(ctrl.count_in);
    acc_carry = |acc_wide[AW-1:SUM_W];
  end

  // Next-state and datapath update; abort outranks the terminal compare
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    sum_d          = sum_q;
    overflow_d     = overflow_q;
    result_valid_d = result_valid_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl.start) begin
          state_d        = S_CLEAR;
          target_d       = ctrl.target;
          sum_d          = '0;
          overflow_d     = 1'b0;
          result_valid_d = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = ctrl.abort ? S_IDLE : S_ACCUM;
      end
      S_ACCUM: begin
        // The value seen in the abort cycle is still added, so the partial
        // sum covers every ACCUM cycle that actually happened.
        sum_d = acc_wide[SUM_W-1:0];
        if (acc_carry) begin
          overflow_d = 1'b1;
        end
        if (ctrl.abort) begin
          state_d = S_IDLE;
        end else if (ctrl.count_in == target_q) begin
          state_d        = S_DONE;
          result_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered
  always_comb begin
    cnt_hard_reset_d = (state_d == S_CLEAR);
    cnt_enable_d     = (state_d == S_ACCUM);
    busy_d           = (state_d == S_CLEAR) || (state_d == S_ACCUM);
    done_d           = (state_d == S_DONE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      target_q         <= '0;
      sum_q            <= '0;
      overflow_q       <= 1'b0;
      result_valid_q   <= 1'b0;
      cnt_enable_q     <= 1'b0;
      cnt_hard_reset_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      sum_q            <= sum_d;
      overflow_q       <= overflow_d;
      result_valid_q   <= result_valid_d;
      cnt_enable_q     <= cnt_enable_d;
      cnt_hard_reset_q <= cnt_hard_reset_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign ctrl.cnt_enable     = cnt_enable_q;
  assign ctrl.cnt_hard_reset = cnt_hard_reset_q;
  assign ctrl.busy           = busy_q;
  assign ctrl.done           = done_q;
  assign ctrl.result_valid   = result_valid_q;
  assign ctrl.sum            = sum_q;
  assign ctrl.overflow       = overflow_q;
  assign ctrl.dbg_state      = state_q;

endmodule

// File: tb/tb_sumatoria_ctrl.sv
// Bench for sumatoria_ctrl: two instances (22-bit and 8-bit sum), each with a
// behavioural up-counter attached. Expected results come from the closed form
// N(N+1)/2 and are queued when a start is issued; monitors pop on done.
module tb_sumatoria_ctrl;
  localparam int CW  = 11;
  localparam int SW  = 22;
  localparam int SW8 = 8;
  localparam int EW  = 32 + 1 + SW;
  localparam int EW8 = 32 + 1 + SW8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cnt_rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sumatoria_ctrl_if #(.COUNT_W(CW), .SUM_W(SW))  bus ();
  sumatoria_ctrl_if #(.COUNT_W(CW), .SUM_W(SW8)) bus8 ();

  sumatoria_ctrl #(.COUNT_W(CW), .SUM_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus)
  );

  sumatoria_ctrl #(.COUNT_W(CW), .SUM_W(SW8)) dut8 (
    .clk (clk),
    .rst (rst),
    .ctrl(bus8)
  );

  // Up-counters with their own reset, so a controller reset leaves them as-is
  logic [CW-1:0] cnt, cnt8;
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) cnt <= '0;
    else if (bus.cnt_hard_reset) cnt <= '0;
    else if (bus.cnt_enable) cnt <= cnt + 1'b1;
  end
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) cnt8 <= '0;
    else if (bus8.cnt_hard_reset) cnt8 <= '0;
    else if (bus8.cnt_enable) cnt8 <= cnt8 + 1'b1;
  end
  assign bus.count_in  = cnt;
  assign bus8.count_in = cnt8;

  // ---------------- scoreboard ----------------
  logic [EW-1:0]  exp_q[$];
  logic [EW8-1:0] exp8_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] tri_sum(input int n);
    if (n < 0) return 64'd0;
    return (64'(n) * 64'(n + 1)) / 64'd2;
  endfunction

  // ---------------- monitors ----------------
  logic [EW-1:0]  mon_e;
  logic [EW8-1:0] mon_e8;
  logic prev_done  = 1'b0;
  logic prev_done8 = 1'b0;

  always @(negedge clk) begin
    if (rst && bus.done) begin
      check("done_pulse", 64'(prev_done), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with no run pending (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", 64'(bus.sum), 64'(mon_e[SW-1:0]));
        check("overflow", 64'(bus.overflow), 64'(mon_e[SW]));
        check("done_cycle", 64'(cyc), 64'(mon_e[EW-1:SW+1]));
        check("result_valid_at_done", 64'(bus.result_valid), 64'd1);
        check("busy_at_done", 64'(bus.busy), 64'd0);
      end
    end
    prev_done = rst && bus.done;
  end

  always @(negedge clk) begin
    if (rst && bus8.done) begin
      check("done_pulse8", 64'(prev_done8), 64'd0);
      if (exp8_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done8: got done with no run pending (t=%0t)", $time);
      end else begin
        mon_e8 = exp8_q.pop_front();
        check("sum8", 64'(bus8.sum), 64'(mon_e8[SW8-1:0]));
        check("overflow8", 64'(bus8.overflow), 64'(mon_e8[SW8]));
        check("done_cycle8", 64'(cyc), 64'(mon_e8[EW8-1:SW8+1]));
      end
    end
    prev_done8 = rst && bus8.done;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel, input logic st, input logic ab, input int tg);
    if (sel) begin
      bus8.start = st; bus8.abort = ab; bus8.target = CW'(tg);
    end else begin
      bus.start = st; bus.abort = ab; bus.target = CW'(tg);
    end
  endtask

  // Issues a one-cycle start from idle; returns at the negedge of the CLEAR cycle
  task automatic start_run(input bit sel, input int n, input bit ab, input bit push);
    logic [63:0] t;
    @(negedge clk);
    drive(sel, 1'b1, ab, n);
    t = tri_sum(n);
    if (push) begin
      if (sel) exp8_q.push_back({32'(cyc + n + 3), t >= (64'd1 << SW8), SW8'(t)});
      else     exp_q.push_back({32'(cyc + n + 3), t >= (64'd1 << SW), SW'(t)});
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, int'($urandom_range(0, 2047)));
  endtask

  // Samples from the current negedge until done; counts enable / clear cycles
  task automatic wait_done(input bit sel, input int bound, output int en_c, output int hr_c);
    int k = 0;
    en_c = 0;
    hr_c = 0;
    while (1) begin
      if (sel ? bus8.cnt_enable : bus.cnt_enable) en_c++;
      if (sel ? bus8.cnt_hard_reset : bus.cnt_hard_reset) hr_c++;
      if (sel ? bus8.done : bus.done) break;
      if (k == bound) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: got no done within %0d cycles", bound);
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic full_run(input int n, input bit ab);
    int en_c, hr_c;
    start_run(1'b0, n, ab, 1'b1);
    wait_done(1'b0, n + 10, en_c, hr_c);
    check("enable_cycles", 64'(en_c), 64'(n + 1));
    check("hard_reset_cycles", 64'(hr_c), 64'd1);
  endtask

  // Abort during the k-th ACCUM cycle (k=0 means during CLEAR)
  task automatic abort_run(input int n, input int k);
    start_run(1'b0, n, 1'b0, 1'b0);
    repeat (k) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_enable", 64'(bus.cnt_enable), 64'd0);
    check("abort_hard_reset", 64'(bus.cnt_hard_reset), 64'd0);
    check("abort_result_valid", 64'(bus.result_valid), 64'd0);
    check("abort_partial_sum", 64'(bus.sum), tri_sum(k - 1) % (64'd1 << SW));
    repeat (4) @(negedge clk);
    check("abort_no_done_rv", 64'(bus.result_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int en_c, hr_c;
    int n;
    logic [63:0] prev_sum;
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 0);
    #2 rst = 1'b0;
    #10;
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result_valid", 64'(bus.result_valid), 64'd0);
    check("rst_enable", 64'(bus.cnt_enable), 64'd0);
    check("rst_hard_reset", 64'(bus.cnt_hard_reset), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt_rst_n = 1'b1;

    // N=10 with a stuck-high view afterwards: result_valid and sum hold
    full_run(10, 1'b0);
    repeat (3) @(negedge clk);
    check("rv_hold", 64'(bus.result_valid), 64'd1);
    check("sum_hold", 64'(bus.sum), tri_sum(10));

    // Boundary targets
    full_run(0, 1'b0);
    full_run(2047, 1'b0);

    // 8-bit accumulator wraps and flags overflow
    start_run(1'b1, 30, 1'b0, 1'b1);
    wait_done(1'b1, 40, en_c, hr_c);
    check("enable_cycles8", 64'(en_c), 64'd31);

    // Aborts: mid-ACCUM, on the terminal cycle, and in CLEAR
    abort_run(100, 20);
    full_run(5, 1'b0);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort_rv", 64'(bus.result_valid), 64'd1);
    check("idle_abort_sum", 64'(bus.sum), tri_sum(5));
    abort_run(7, 8);
    abort_run(9, 0);

    // Start re-pulsed while busy is ignored
    start_run(1'b0, 50, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3);
    wait_done(1'b0, 60, en_c, hr_c);

    // Asynchronous reset mid-ACCUM, then a fresh run
    start_run(1'b0, 50, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_enable", 64'(bus.cnt_enable), 64'd0);
    check("async_rst_sum", 64'(bus.sum), 64'd0);
    check("async_rst_rv", 64'(bus.result_valid), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    full_run(4, 1'b0);

    // Randomised runs; abort raised alongside start, and in DONE/IDLE, is inert
    prev_sum = tri_sum(4);
    for (int r = 0; r < 12; r++) begin
      bus.abort = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check("rand_sum_hold", 64'(bus.sum), prev_sum);
      check("rand_rv_hold", 64'(bus.result_valid), 64'd1);
      n = int'($urandom_range(0, 120));
      full_run(n, 1'($urandom_range(0, 1)));
      prev_sum = tri_sum(n);
    end
    bus.abort = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("queue8_drained", 64'(exp8_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test before time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sumatoria_ctrl.md
Name: sumatoria_ctrl

Overview:
- Control and accumulate stage for the Sumatoria datapath.
- Drives the team's up-counter (enable, hardReset) and consumes its count output.
- Accumulates the count values to compute S = 0+1+...+N for a requested N.
- Start/busy/done handshake toward the upstream host; registered result with overflow flag.

Parameters:
- COUNT_W, 11, width of target and count_in.
- SUM_W, 22, width of the sum accumulator and result (22 bits holds 2047*2048/2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request, sampled in IDLE only.
- abort  input  1  synchronous abort, honoured in CLEAR and ACCUM.
- target  input  COUNT_W  N, captured into target_q on accepted start.
- count_in  input  COUNT_W  registered count from the counter.
- cnt_enable  output  1  counter enable, registered.
- cnt_hard_reset  output  1  counter synchronous clear, registered.
- busy  output  1  high in CLEAR and ACCUM.
- done  output  1  one-cycle pulse: result is complete.
- result_valid  output  1  high from done until the next accepted start.
- sum  output  SUM_W  accumulated result.
- overflow  output  1  sticky: carry out of the SUM_W adder in the current run.

Behaviour:
- Reset (rst=0, async): state=IDLE; target_q=0; cnt_enable, cnt_hard_reset, busy, done, result_valid, overflow, sum all 0.
- Reset mid-run returns to IDLE immediately. The counter is not cleared by this block; the next run's CLEAR handles it.
- States: IDLE, CLEAR, ACCUM, DONE. All outputs are registered and reflect the current state.
- IDLE:
  - start=1 -> CLEAR; target_q<=target; sum<=0; overflow<=0; result_valid<=0.
  - start=0 -> stay; sum, overflow and result_valid hold.
- CLEAR (exactly 1 cycle): cnt_hard_reset=1, cnt_enable=0, busy=1. Next state ACCUM, so the counter presents count_in=0 in the first ACCUM cycle.
- ACCUM: cnt_enable=1, busy=1.
  - Every cycle: sum<=sum+count_in, zero-extended, modulo 2^SUM_W.
  - Carry out sets overflow=1 (sticky).
  - count_in==target_q -> DONE, after adding that value.
  - The counter increments on the exiting edge (enable still 1). This is harmless.
- DONE (1 cycle): done=1, result_valid=1, busy=0, cnt_enable=0. Next state IDLE.
- Latency: done is high in the cycle N+3 edges after the edge that sampled start (1 CLEAR + N+1 ACCUM + entry to DONE). ACCUM lasts N+1 cycles.
- Result: sum = N(N+1)/2 mod 2^SUM_W. overflow=1 iff N(N+1)/2 >= 2^SUM_W.
- N=0: one ACCUM cycle, sum=0, done at edge 3.
- N=2^COUNT_W-1: terminates on equality; no wrap of count_in is needed.
- Start while busy or in DONE is ignored. No queueing.
- abort=1 in CLEAR/ACCUM:
  - Next state IDLE; cnt_enable=0, cnt_hard_reset=0, busy=0.
  - No done, result_valid stays 0; sum holds the partial value.
  - abort has priority over the terminal compare in the same cycle.
  - abort in IDLE or DONE has no effect.
- start and abort high together in IDLE: start is accepted; abort is ignored that cycle.
- target changes after acceptance have no effect (target_q is used).
- count_in is trusted. A skipped value that never equals target_q hangs in ACCUM until abort. This is documented, not protected.

Test Plan:
- Reset, then start with target=10, counter instance attached: cnt_hard_reset high 1 cycle, cnt_enable for 11 cycles, done pulse 13 edges after start, sum=55, overflow=0, result_valid stays 1.
- target=0: sum=0, done 3 edges after start, exactly one ACCUM cycle. target=2047, SUM_W=22: sum=2096128, overflow=0, done at edge 2050.
- SUM_W=8, target=30: sum=209 (465 mod 256), overflow=1, done still pulses once.
- target=100, abort in the 20th ACCUM cycle: next cycle IDLE, no done, result_valid=0, sum=190. A later start with target=5 yields sum=15 and overflow=0.
- target=50, start re-pulsed during ACCUM with target=3: ignored, final sum=1275. Reassert rst=0 mid-ACCUM: all outputs 0 asynchronously; the following start with target=4 yields sum=10.
